// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decoded ID fields and controls in, registered EX fields and enables out.
interface id_ex_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = 32
);
  logic            id_valid_i;
  logic [XLEN-1:0] id_pc_i;
  logic [4:0]      id_rs1_i;
  logic [4:0]      id_rs2_i;
  logic [4:0]      id_rd_i;
  logic            id_use_rs1_i;
  logic            id_use_rs2_i;
  logic [XLEN-1:0] id_rs1data_i;
  logic [XLEN-1:0] id_rs2data_i;
  logic [XLEN-1:0] id_imm_i;
  logic [9:0]      id_funct_i;
  logic [6:0]      id_ctrl_i;
  logic            br_flush_i;
  logic            mem_stall_i;

  logic            pc_write_o;
  logic            ifid_write_o;
  logic            ex_valid_o;
  logic [XLEN-1:0] ex_pc_o;
  logic [XLEN-1:0] ex_rs1data_o;
  logic [XLEN-1:0] ex_rs2data_o;
  logic [XLEN-1:0] ex_imm_o;
  logic [4:0]      ex_rs1_o;
  logic [4:0]      ex_rs2_o;
  logic [4:0]      ex_rd_o;
  logic [9:0]      ex_funct_o;
  logic [6:0]      ex_ctrl_o;
  logic [CNTW-1:0] bubble_cnt_o;

  modport master (
    output id_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rd_i, id_use_rs1_i, id_use_rs2_i,
           id_rs1data_i, id_rs2data_i, id_imm_i, id_funct_i, id_ctrl_i, br_flush_i, mem_stall_i,
    input  pc_write_o, ifid_write_o, ex_valid_o, ex_pc_o, ex_rs1data_o, ex_rs2data_o, ex_imm_o,
           ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct_o, ex_ctrl_o, bubble_cnt_o
  );

  modport slave (
    input  id_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rd_i, id_use_rs1_i, id_use_rs2_i,
           id_rs1data_i, id_rs2data_i, id_imm_i, id_funct_i, id_ctrl_i, br_flush_i, mem_stall_i,
    output pc_write_o, ifid_write_o, ex_valid_o, ex_pc_o, ex_rs1data_o, ex_rs2data_o, ex_imm_o,
           ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct_o, ex_ctrl_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch kill, memory-stall freeze
// and a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = 32
) (
  input logic   clk_i,
  input logic   rst_i,
  id_ex_if.slave bus
);
  // ctrl packing: {regwrite, memtoreg, memread, memwrite, alusrc, aluop[1:0]}
  localparam int unsigned MemReadBit = 4;

  logic            valid_q;
  logic [XLEN-1:0] pc_q, rs1data_q, rs2data_q, imm_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [9:0]      funct_q;
  logic [6:0]      ctrl_q;
  logic [CNTW-1:0] cnt_q;

  logic hazard;
  logic bubble;
  logic capture;
  logic front_en;

  assign hazard = bus.id_valid_i & valid_q & ctrl_q[MemReadBit] & (rd_q != 5'd0) &
                  ((bus.id_use_rs1_i & (rd_q == bus.id_rs1_i)) |
                   (bus.id_use_rs2_i & (rd_q == bus.id_rs2_i)));

  assign bubble  = ~bus.mem_stall_i & (bus.br_flush_i | hazard);
  assign capture = ~bus.mem_stall_i & ~bus.br_flush_i & ~hazard;

  // Flush still lets the front end advance to the branch target; a load-use holds it.
  always_comb begin
    front_en = 1'b1;
    if (bus.mem_stall_i) begin
      front_en = 1'b0;
    end else if (bus.br_flush_i) begin
      front_en = 1'b1;
    end else if (hazard) begin
      front_en = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs1data_q <= '0;
      rs2data_q <= '0;
      imm_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      funct_q   <= '0;
      ctrl_q    <= '0;
    end else if (bubble) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs1data_q <= '0;
      rs2data_q <= '0;
      imm_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      funct_q   <= '0;
      ctrl_q    <= '0;
    end else if (capture) begin
      valid_q   <= bus.id_valid_i;
      pc_q      <= bus.id_pc_i;
      rs1data_q <= bus.id_rs1data_i;
      rs2data_q <= bus.id_rs2data_i;
      imm_q     <= bus.id_imm_i;
      rs1_q     <= bus.id_rs1_i;
      rs2_q     <= bus.id_rs2_i;
      rd_q      <= bus.id_rd_i;
      funct_q   <= bus.id_funct_i;
      // An invalid slot must never carry side-effecting control into EX.
      ctrl_q    <= bus.id_valid_i ? bus.id_ctrl_i : 7'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (bubble && (cnt_q != {CNTW{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.pc_write_o   = front_en;
  assign bus.ifid_write_o = front_en;
  assign bus.ex_valid_o   = valid_q;
  assign bus.ex_pc_o      = pc_q;
  assign bus.ex_rs1data_o = rs1data_q;
  assign bus.ex_rs2data_o = rs2data_q;
  assign bus.ex_imm_o     = imm_q;
  assign bus.ex_rs1_o     = rs1_q;
  assign bus.ex_rs2_o     = rs2_q;
  assign bus.ex_rd_o      = rd_q;
  assign bus.ex_funct_o   = funct_q;
  assign bus.ex_ctrl_o    = ctrl_q;
  assign bus.bubble_cnt_o = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against a
// behavioural pipeline model; a second instance with a 3-bit counter exercises saturation.
module tb_id_ex_stage;
  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_if #(.XLEN(XLEN), .CNTW(32)) bus ();
  id_ex_if #(.XLEN(XLEN), .CNTW(3))  sbus ();

  id_ex_stage #(.XLEN(XLEN), .CNTW(32)) dut  (.clk_i(clk), .rst_i(rst_n), .bus(bus));
  id_ex_stage #(.XLEN(XLEN), .CNTW(3))  sdut (.clk_i(clk), .rst_i(rst_n), .bus(sbus));

  // Stimulus, shared by both instances.
  logic            v_valid, v_use1, v_use2, v_flush, v_stall;
  logic [XLEN-1:0] v_pc, v_rs1d, v_rs2d, v_imm;
  logic [4:0]      v_rs1, v_rs2, v_rd;
  logic [9:0]      v_funct;
  logic [6:0]      v_ctrl;

  assign bus.id_valid_i   = v_valid;   assign sbus.id_valid_i   = v_valid;
  assign bus.id_pc_i      = v_pc;      assign sbus.id_pc_i      = v_pc;
  assign bus.id_rs1_i     = v_rs1;     assign sbus.id_rs1_i     = v_rs1;
  assign bus.id_rs2_i     = v_rs2;     assign sbus.id_rs2_i     = v_rs2;
  assign bus.id_rd_i      = v_rd;      assign sbus.id_rd_i      = v_rd;
  assign bus.id_use_rs1_i = v_use1;    assign sbus.id_use_rs1_i = v_use1;
  assign bus.id_use_rs2_i = v_use2;    assign sbus.id_use_rs2_i = v_use2;
  assign bus.id_rs1data_i = v_rs1d;    assign sbus.id_rs1data_i = v_rs1d;
  assign bus.id_rs2data_i = v_rs2d;    assign sbus.id_rs2data_i = v_rs2d;
  assign bus.id_imm_i     = v_imm;     assign sbus.id_imm_i     = v_imm;
  assign bus.id_funct_i   = v_funct;   assign sbus.id_funct_i   = v_funct;
  assign bus.id_ctrl_i    = v_ctrl;    assign sbus.id_ctrl_i    = v_ctrl;
  assign bus.br_flush_i   = v_flush;   assign sbus.br_flush_i   = v_flush;
  assign bus.mem_stall_i  = v_stall;   assign sbus.mem_stall_i  = v_stall;

  localparam logic [6:0] CtrlLw  = 7'b1110100;
  localparam logic [6:0] CtrlAdd = 7'b1000010;

  // Reference model: what instruction sits in EX, and how many bubbles have been issued.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc, rs1d, rs2d, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [9:0]      funct;
    logic [6:0]      ctrl;
  } ex_t;

  ex_t         m_ex;
  logic [31:0] m_cnt;
  int          m_scnt;
  int          n_pass = 0;
  int          n_total = 0;

  wire ex_t act_ex = '{valid: bus.ex_valid_o, pc: bus.ex_pc_o, rs1d: bus.ex_rs1data_o,
                       rs2d: bus.ex_rs2data_o, imm: bus.ex_imm_o, rs1: bus.ex_rs1_o,
                       rs2: bus.ex_rs2_o, rd: bus.ex_rd_o, funct: bus.ex_funct_o,
                       ctrl: bus.ex_ctrl_o};

  function automatic bit model_load_use();
    bit is_load = m_ex.valid && m_ex.ctrl[4];
    bit reads_it = (v_use1 && v_rs1 == m_ex.rd) || (v_use2 && v_rs2 == m_ex.rd);
    return v_valid && is_load && (m_ex.rd != 0) && reads_it;
  endfunction

  function automatic bit model_front_en();
    if (v_stall) return 1'b0;
    if (v_flush) return 1'b1;
    return !model_load_use();
  endfunction

  function automatic void model_step();
    if (v_stall) return;
    if (v_flush || model_load_use()) begin
      m_ex = '0;
      if (m_cnt != 32'hffff_ffff) m_cnt = m_cnt + 1;
      if (m_scnt < 7) m_scnt = m_scnt + 1;
    end else begin
      m_ex = '{valid: v_valid, pc: v_pc, rs1d: v_rs1d, rs2d: v_rs2d, imm: v_imm, rs1: v_rs1,
               rs2: v_rs2, rd: v_rd, funct: v_funct, ctrl: v_valid ? v_ctrl : 7'd0};
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic u1, input logic u2, input logic [6:0] ctrl);
    v_valid = 1'b1; v_rs1 = rs1; v_rs2 = rs2; v_rd = rd; v_use1 = u1; v_use2 = u2;
    v_ctrl = ctrl; v_pc = $urandom; v_rs1d = $urandom; v_rs2d = $urandom; v_imm = $urandom;
    v_funct = 10'($urandom);
  endtask

  task automatic rand_id();
    v_valid = ($urandom_range(0, 4) != 0);
    v_rs1 = 5'($urandom_range(0, 7)); v_rs2 = 5'($urandom_range(0, 7));
    v_rd = 5'($urandom_range(0, 7));
    v_use1 = 1'($urandom); v_use2 = 1'($urandom);
    v_ctrl = 7'($urandom) | (($urandom_range(0, 1) != 0) ? 7'b0010000 : 7'd0);
    v_pc = $urandom; v_rs1d = $urandom; v_rs2d = $urandom; v_imm = $urandom;
    v_funct = 10'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    m_ex = '0; m_cnt = 0; m_scnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    v_valid = 0; v_flush = 0; v_stall = 0; v_ctrl = 0; v_use1 = 0; v_use2 = 0;
    do_reset();
    n_total++;
    if (act_ex !== ex_t'('0) || bus.bubble_cnt_o !== 32'd0) begin
      $display("FAIL reset_state: ex=%h cnt=%0d, required all zero", act_ex, bus.bubble_cnt_o);
    end else n_pass++;
    n_total++;
    if (bus.pc_write_o !== 1'b1 || bus.ifid_write_o !== 1'b1) begin
      $display("FAIL reset_enables: pc_write=%b ifid_write=%b, required 1/1",
               bus.pc_write_o, bus.ifid_write_o);
    end else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_instr(5'd2, 5'd0, 5'd5, 1'b1, 1'b0, CtrlLw);
    tick();
    set_instr(5'd5, 5'd7, 5'd6, 1'b1, 1'b1, CtrlAdd);
    #1;
    n_total++;
    if (bus.pc_write_o !== 1'b0 || bus.ifid_write_o !== 1'b0) begin
      $display("FAIL load_use_stall: pc_write=%b ifid_write=%b, required 0/0",
               bus.pc_write_o, bus.ifid_write_o);
    end else n_pass++;
    tick();
    n_total++;
    if (bus.ex_valid_o !== 1'b0 || bus.ex_ctrl_o !== 7'd0 || bus.bubble_cnt_o !== 32'd1) begin
      $display("FAIL load_use_bubble: valid=%b ctrl=%h cnt=%0d, required 0/00/1",
               bus.ex_valid_o, bus.ex_ctrl_o, bus.bubble_cnt_o);
    end else n_pass++;
    n_total++;
    if (bus.pc_write_o !== 1'b1) begin
      $display("FAIL load_use_release: pc_write=%b, required 1", bus.pc_write_o);
    end else n_pass++;
    tick();
    n_total++;
    if (bus.ex_rs1_o !== 5'd5 || bus.ex_valid_o !== 1'b1 || act_ex !== m_ex) begin
      $display("FAIL load_use_capture: ex=%h, required %h", act_ex, m_ex);
    end else n_pass++;
  endtask

  task automatic test_no_hazard();
    set_instr(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, CtrlLw);
    tick();
    set_instr(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, CtrlAdd);
    #1;
    n_total++;
    if (bus.pc_write_o !== 1'b1 || bus.ifid_write_o !== 1'b1) begin
      $display("FAIL x0_no_stall: pc_write=%b ifid_write=%b, required 1/1",
               bus.pc_write_o, bus.ifid_write_o);
    end else n_pass++;
    set_instr(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CtrlLw);
    tick();
    set_instr(5'd8, 5'd5, 5'd6, 1'b1, 1'b0, CtrlAdd);
    #1;
    n_total++;
    if (bus.pc_write_o !== 1'b1 || bus.ifid_write_o !== 1'b1) begin
      $display("FAIL unused_rs2_no_stall: pc_write=%b ifid_write=%b, required 1/1",
               bus.pc_write_o, bus.ifid_write_o);
    end else n_pass++;
    tick();
    n_total++;
    if (act_ex !== m_ex || bus.ex_rd_o !== 5'd6) begin
      $display("FAIL addi_capture: ex=%h, required %h", act_ex, m_ex);
    end else n_pass++;
  endtask

  task automatic test_mem_stall();
    ex_t         snap = m_ex;
    logic [31:0] cnt0 = m_cnt;
    v_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      v_flush = 1'($urandom);
      #1;
      n_total++;
      if (bus.pc_write_o !== 1'b0 || bus.ifid_write_o !== 1'b0) begin
        $display("FAIL stall_enables[%0d]: pc_write=%b ifid_write=%b, required 0/0",
                 i, bus.pc_write_o, bus.ifid_write_o);
      end else n_pass++;
      tick();
      n_total++;
      if (act_ex !== snap || bus.bubble_cnt_o !== cnt0) begin
        $display("FAIL stall_hold[%0d]: ex=%h cnt=%0d, required %h cnt=%0d",
                 i, act_ex, bus.bubble_cnt_o, snap, cnt0);
      end else n_pass++;
    end
    v_stall = 1'b0; v_flush = 1'b0;
  endtask

  task automatic test_flush_over_hazard();
    logic [31:0] cnt0;
    set_instr(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CtrlLw);
    tick();
    cnt0 = m_cnt;
    set_instr(5'd5, 5'd5, 5'd6, 1'b1, 1'b1, CtrlAdd);
    v_flush = 1'b1;
    #1;
    n_total++;
    if (bus.pc_write_o !== 1'b1 || bus.ifid_write_o !== 1'b1) begin
      $display("FAIL flush_enables: pc_write=%b ifid_write=%b, required 1/1",
               bus.pc_write_o, bus.ifid_write_o);
    end else n_pass++;
    tick();
    n_total++;
    if (act_ex !== ex_t'('0) || bus.bubble_cnt_o !== cnt0 + 32'd1) begin
      $display("FAIL flush_bubble: ex=%h cnt=%0d, required 0 cnt=%0d",
               act_ex, bus.bubble_cnt_o, cnt0 + 32'd1);
    end else n_pass++;
    v_flush = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    v_flush = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      rand_id();
      tick();
      n_total++;
      if (int'(sbus.bubble_cnt_o) !== ((i < 7) ? i : 7)) begin
        $display("FAIL saturate[%0d]: cnt=%0d, required %0d", i, sbus.bubble_cnt_o,
                 (i < 7) ? i : 7);
      end else n_pass++;
    end
    v_flush = 1'b0;
  endtask

  task automatic test_async_reset();
    set_instr(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CtrlLw);
    tick();
    set_instr(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, CtrlAdd);
    v_stall = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    m_ex = '0; m_cnt = 0; m_scnt = 0;
    n_total++;
    if (act_ex !== ex_t'('0) || bus.bubble_cnt_o !== 32'd0) begin
      $display("FAIL async_reset: ex=%h cnt=%0d, required all zero", act_ex, bus.bubble_cnt_o);
    end else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    v_stall = 1'b0;
    tick();
    n_total++;
    if (act_ex !== m_ex || bus.ex_rd_o !== 5'd6 || bus.bubble_cnt_o !== 32'd0) begin
      $display("FAIL post_reset_capture: ex=%h cnt=%0d, required %h cnt=0",
               act_ex, bus.bubble_cnt_o, m_ex);
    end else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      rand_id();
      v_stall = ($urandom_range(0, 7) == 0);
      v_flush = ($urandom_range(0, 7) == 0);
      #1;
      n_total++;
      if (bus.pc_write_o !== model_front_en() || bus.ifid_write_o !== model_front_en()) begin
        if (errs++ < 10) $display("FAIL rand_enables[%0d]: pc_write=%b ifid_write=%b, required %b",
                                  i, bus.pc_write_o, bus.ifid_write_o, model_front_en());
      end else n_pass++;
      tick();
      n_total++;
      if (act_ex !== m_ex || bus.bubble_cnt_o !== m_cnt || int'(sbus.bubble_cnt_o) !== m_scnt)
      begin
        if (errs++ < 10) $display("FAIL rand_state[%0d]: ex=%h cnt=%0d/%0d, required %h cnt=%0d/%0d",
                                  i, act_ex, bus.bubble_cnt_o, sbus.bubble_cnt_o, m_ex, m_cnt,
                                  m_scnt);
      end else n_pass++;
    end
    v_stall = 1'b0; v_flush = 1'b0;
  endtask

  initial begin
    v_valid = 0; v_pc = 0; v_rs1 = 0; v_rs2 = 0; v_rd = 0; v_use1 = 0; v_use2 = 0;
    v_rs1d = 0; v_rs2d = 0; v_imm = 0; v_funct = 0; v_ctrl = 0; v_flush = 0; v_stall = 0;
    m_ex = '0; m_cnt = 0; m_scnt = 0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mem_stall();
    test_flush_over_hazard();
    test_saturate();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
